multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the RV32 core. It replaces single-cycle control with a Moore state machine that steps the shared datapath (PC, instruction register, one ALU, one memory port, register file) through fetch, decode, execute, memory and writeback. Every multi-cycle phase that touches memory waits on a ready handshake. `op`, `funct3` and `funct7b5` come from the instruction register and are stable from DECODE until the next FETCH completes.

## Interface

Parameters:

- `STATE_W`, default 4: width of the state register and the `state` debug port.

Ports:

- `clk` input 1: the single clock; all state changes occur on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `op` input 7: opcode from the instruction register.
- `funct3` input 3: instruction funct3.
- `funct7b5` input 1: instruction bit 30.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory port completes the current access this cycle.
- `pc_write` output 1: load the PC from the result bus.
- `ir_write` output 1: load the instruction register and oldPC.
- `adr_src` output 1: memory address source; 0 selects PC, 1 selects ALUOut.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `reg_write` output 1: register file write enable.
- `result_src` output 2: result select; 00 selects ALUOut, 01 selects memory data, 10 selects the ALU result directly.
- `alu_src_a` output 2: ALU A select; 00 selects PC, 01 selects oldPC, 10 selects rs1.
- `alu_src_b` output 2: ALU B select; 00 selects rs2, 01 selects imm, 10 selects the constant 4.
- `alu_control` output 4: ALU operation. `4'b0000` is ADD and `4'b1000` is SUB.
- `imm_src` output 2: immediate format; 00 is I, 01 is S, 10 is B, 11 is J.
- `illegal` output 1: sticky flag for an unsupported instruction.
- `state` output `STATE_W`: current state, for debug only.

## Operation

States and encodings:

- FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
- EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, TRAP = 11
- Encodings 12–15 are unused and go to FETCH.

Outputs are pure Moore decode of the state. The exceptions are the `mem_ready`, `zero` and `funct*` terms listed below. Any signal not listed for a state is 0.

- **FETCH:** `mem_read`=1, `adr_src`=0, a=00, b=10, ADD, `result_src`=10. `ir_write` and `pc_write` equal `mem_ready`. Stay in FETCH until `mem_ready`, then go to DECODE.
- **DECODE:** a=01, b=01, ADD, so ALUOut holds the branch/jump target. `imm_src` follows `op`. Next state by `op`:
  - 0000011 (lw) and 0100011 (sw) go to MEMADR.
  - 0110011 goes to EXECR.
  - 0010011 goes to EXECI.
  - 1100011 goes to BRANCH if `funct3` is 000 or 001; any other `funct3` goes to TRAP.
  - 1101111 goes to JAL.
  - Any other opcode goes to TRAP.
- **MEMADR:** a=10, b=01, ADD. Next state is MEMREAD if `op[5]`=0, otherwise MEMWRITE.
- **MEMREAD:** `adr_src`=1, `mem_read`=1. Hold until `mem_ready`, then go to MEMWB.
- **MEMWB:** `result_src`=01, `reg_write`=1, then go to FETCH.
- **MEMWRITE:** `adr_src`=1, `mem_write`=1. Hold until `mem_ready`, then go to FETCH.
- **EXECR:** a=10, b=00, `alu_control`={`funct7b5`,`funct3`}, then go to ALUWB.
- **EXECI:** a=10, b=01. `alu_control`={`funct7b5`&(`funct3`==101), `funct3`}. Then go to ALUWB.
- **ALUWB:** `result_src`=00, `reg_write`=1, then go to FETCH.
- **BRANCH:** a=10, b=00, SUB, `result_src`=00. `pc_write`=`zero`^`funct3[0]`: beq is taken on `zero`, bne on !`zero`. Then go to FETCH.
- **JAL:** a=01, b=10, ADD, `result_src`=00, `pc_write`=1. The PC takes the target in ALUOut while the ALU forms PC+4. Then go to ALUWB.
- **TRAP:** all strobes are 0 and `illegal`=1. TRAP is terminal until reset.

`imm_src` is decoded from `op` in every state: I for loads, I-ALU and the default; S for stores; B for branches; J for jal.

## Timing

- Reset: asynchronous assertion forces `state`=FETCH and clears `illegal`. While `rst_n` is 0, `pc_write`, `ir_write`, `reg_write`, `mem_read` and `mem_write` are forced to 0. All other outputs take their FETCH values.
- Deassertion is synchronous to the next `clk` rise. The first fetch request appears in the first cycle after deassertion.
- Reset mid-instruction abandons the instruction. No partial register or memory write may occur after `rst_n` falls.
- Latency with zero wait states (`mem_ready` held at 1), in cycles:
  - R-type and I-ALU: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - jal: 4
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. The request and address stay stable throughout the wait.
- A write strobe never asserts for more than one cycle per instruction. The exceptions are `mem_write` and `mem_read`, which hold while waiting.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 cycles mid-MEMWRITE → `mem_write`=0 immediately. `state`=0. After release, FETCH with `mem_read`=1.
- **add x3,x1,x2** (op 0110011, f3 000, f7b5 0), `mem_ready`=1 → states 0,1,6,8,0. `alu_control`=0000 in EXECR. `reg_write`=1 only in ALUWB.
- **sub then srai:** sub (f7b5 1, f3 000) → `alu_control`=1000. srai (op 0010011, f3 101, f7b5 1) → 1101. addi with f7b5=1 → 0000.
- **lw with waits:** `mem_ready`=0 for 2 cycles in FETCH and 3 cycles in MEMREAD → 10 cycles total. `ir_write` pulses once. `reg_write` with `result_src`=01 pulses once.
- **Branches:**
  - beq with `zero`=1 → `pc_write`=1 in BRANCH.
  - beq with `zero`=0 → `pc_write`=0.
  - bne with `zero`=0 → `pc_write`=1.
  - Each takes 3 cycles back to FETCH.
- **Illegal:**
  - op 1110011 → TRAP after DECODE, `illegal`=1, all strobes 0 for 20 cycles.
  - Branch with f3 100 → TRAP.
  - Reset clears `illegal`.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle RV32 datapath.
// Steps fetch/decode/execute/memory/writeback over one shared ALU and memory port.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               adr_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         alu_control,
  output logic [1:0]         imm_src,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  state_t state_q;
  state_t state_d;
  logic   illegal_q;

  logic pc_write_s;
  logic ir_write_s;
  logic mem_read_s;
  logic mem_write_s;
  logic reg_write_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == TRAP);
    end
  end

  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          (op == OP_LW) || (op == OP_SW):
            state_d = MEMADR;
          op == OP_R:
            state_d = EXECR;
          op == OP_I:
            state_d = EXECI;
          op == OP_B:
            state_d = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
          op == OP_JAL:
            state_d = JAL;
          default:
            state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JAL:      state_d = ALUWB;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    adr_src     = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    unique case (state_q)
      FETCH: begin
        mem_read_s = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        mem_read_s = 1'b1;
      end
      MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = {funct7b5, funct3};
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        // only srai uses bit 30; addi etc. ignore it
        alu_control = {funct7b5 & (funct3 == 3'b101), funct3};
      end
      ALUWB: begin
        reg_write_s = 1'b1;
      end
      BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write_s  = zero ^ funct3[0];
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_s = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    unique case (op)
      OP_SW:   imm_src = 2'b01;
      OP_B:    imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // strobes are masked combinationally so nothing fires while rst_n is low
  assign pc_write  = pc_write_s  & rst_n;
  assign ir_write  = ir_write_s  & rst_n;
  assign mem_read  = mem_read_s  & rst_n;
  assign mem_write = mem_write_s & rst_n;
  assign reg_write = reg_write_s & rst_n;
  assign illegal   = illegal_q;
  assign state     = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// Hand-computed state sequences, strobes and latencies.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;
  logic [1:0] imm_src;
  logic       illegal;
  logic [3:0] state;

  int passed = 0;
  int total  = 0;
  int cnt_en = 0;
  int cyc_n  = 0;
  int irw_n  = 0;
  int rw_n   = 0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_en != 0) begin
      cyc_n += 1;
      irw_n += int'(ir_write);
      if (reg_write && result_src == 2'b01) rw_n += 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [4:0] strobes();
    return {pc_write, ir_write, reg_write, mem_read, mem_write};
  endfunction

  initial begin
    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("rst_state", state, 0);
    chk("rst_strobes", strobes(), 0);
    chk("rst_alub", alu_src_b, 2'b10);
    chk("rst_res", result_src, 2'b10);
    chk("rst_illegal", illegal, 0);
    tick();
    tick();
    chk("rst_hold_state", state, 0);

    // add x3,x1,x2
    rst_n = 1'b1; #1;
    chk("add_f_state", state, 0);
    chk("add_f_mem_read", mem_read, 1);
    chk("add_f_ir_write", ir_write, 1);
    tick();
    chk("add_d_state", state, 1);
    chk("add_d_srca", alu_src_a, 2'b01);
    chk("add_d_srcb", alu_src_b, 2'b01);
    tick();
    chk("add_e_state", state, 6);
    chk("add_e_alu", alu_control, 4'b0000);
    chk("add_e_rw", reg_write, 0);
    tick();
    chk("add_w_state", state, 8);
    chk("add_w_rw", reg_write, 1);
    chk("add_w_res", result_src, 2'b00);
    tick();
    chk("add_end_state", state, 0);

    // sub
    funct7b5 = 1'b1;
    tick(); tick();
    chk("sub_state", state, 6);
    chk("sub_alu", alu_control, 4'b1000);
    tick(); tick();
    chk("sub_end", state, 0);

    // srai
    op = 7'b0010011; funct3 = 3'b101; funct7b5 = 1'b1;
    tick();
    chk("srai_imm", imm_src, 2'b00);
    tick();
    chk("srai_state", state, 7);
    chk("srai_alu", alu_control, 4'b1101);
    chk("srai_srcb", alu_src_b, 2'b01);
    tick(); tick();
    chk("srai_end", state, 0);

    // addi with bit 30 set
    funct3 = 3'b000;
    tick(); tick();
    chk("addi_alu", alu_control, 4'b0000);
    tick();
    chk("addi_wb", state, 8);
    tick();

    // lw: 2 fetch waits, 3 read waits
    op = 7'b0000011; mem_ready = 1'b0; cnt_en = 1;
    cyc_n = 0; irw_n = 0; rw_n = 0; #1;
    chk("lw_fwait_ir", ir_write, 0);
    chk("lw_fwait_rd", mem_read, 1);
    tick();
    chk("lw_fwait_state", state, 0);
    tick();
    mem_ready = 1'b1; #1;
    chk("lw_f_ir", ir_write, 1);
    tick();
    chk("lw_d_state", state, 1);
    tick();
    chk("lw_adr_state", state, 2);
    chk("lw_adr_srca", alu_src_a, 2'b10);
    tick();
    mem_ready = 1'b0; #1;
    chk("lw_rd_state", state, 3);
    chk("lw_rd_adr", adr_src, 1);
    chk("lw_rd_req", mem_read, 1);
    tick(); tick();
    chk("lw_rdwait_state", state, 3);
    chk("lw_rdwait_adr", adr_src, 1);
    tick();
    mem_ready = 1'b1;
    tick();
    chk("lw_wb_state", state, 4);
    chk("lw_wb_res", result_src, 2'b01);
    chk("lw_wb_rw", reg_write, 1);
    tick();
    cnt_en = 0;
    chk("lw_end", state, 0);
    chk("lw_cycles", cyc_n, 10);
    chk("lw_ir_pulses", irw_n, 1);
    chk("lw_rw_pulses", rw_n, 1);

    // sw
    op = 7'b0100011;
    tick();
    chk("sw_imm", imm_src, 2'b01);
    tick();
    chk("sw_adr", state, 2);
    tick();
    chk("sw_wr_state", state, 5);
    chk("sw_wr", mem_write, 1);
    tick();
    chk("sw_end", state, 0);

    // beq taken
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    tick();
    chk("beq_imm", imm_src, 2'b10);
    tick();
    chk("beq_state", state, 9);
    chk("beq_alu", alu_control, 4'b1000);
    chk("beq_t_pcw", pc_write, 1);
    tick();
    chk("beq_end", state, 0);
    // beq not taken
    zero = 1'b0;
    tick(); tick();
    chk("beq_nt_pcw", pc_write, 0);
    tick();
    chk("beq_nt_end", state, 0);
    // bne taken
    funct3 = 3'b001;
    tick(); tick();
    chk("bne_t_pcw", pc_write, 1);
    tick();
    chk("bne_end", state, 0);

    // jal
    op = 7'b1101111;
    tick();
    chk("jal_imm", imm_src, 2'b11);
    tick();
    chk("jal_state", state, 10);
    chk("jal_pcw", pc_write, 1);
    chk("jal_srca", alu_src_a, 2'b01);
    chk("jal_srcb", alu_src_b, 2'b10);
    tick();
    chk("jal_wb", state, 8);
    tick();
    chk("jal_end", state, 0);

    // reset in the middle of a stalled store
    op = 7'b0100011; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("mrst_pre_wr", mem_write, 1);
    rst_n = 1'b0; #1;
    chk("mrst_wr", mem_write, 0);
    chk("mrst_state", state, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_hold_strobes", strobes(), 0);
    end
    rst_n = 1'b1; #1;
    chk("mrst_rel_state", state, 0);
    chk("mrst_rel_rd", mem_read, 1);

    // ecall-style opcode
    op = 7'b1110011; mem_ready = 1'b1;
    tick();
    chk("ill_d_state", state, 1);
    chk("ill_d_flag", illegal, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("ill_state", state, 11);
      chk("ill_flag", illegal, 1);
      chk("ill_strobes", strobes(), 0);
    end
    rst_n = 1'b0; #1;
    chk("ill_rst_clear", illegal, 0);
    tick();
    rst_n = 1'b1;

    // branch with unsupported funct3
    op = 7'b1100011; funct3 = 3'b100;
    tick(); tick();
    chk("bill_state", state, 11);
    chk("bill_flag", illegal, 1);
    rst_n = 1'b0; #1;
    chk("bill_rst_clear", illegal, 0);
    chk("bill_rst_state", state, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
